// File: rtl/crtc_pkg.sv
// Shared definitions for the CRTC raster timing path: register indices, field widths, FSM states.
package crtc_pkg;

    localparam int MA_WIDTH = 14;
    localparam int RA_WIDTH = 5;

    typedef enum logic [4:0] {
        R0_H_TOTAL        = 5'd0,
        R1_H_DISPLAYED    = 5'd1,
        R2_H_SYNC_POS     = 5'd2,
        R3_SYNC_WIDTHS    = 5'd3,
        R4_V_TOTAL        = 5'd4,
        R5_V_TOTAL_ADJ    = 5'd5,
        R6_V_DISPLAYED    = 5'd6,
        R7_V_SYNC_POS     = 5'd7,
        R8_MODE_CTRL      = 5'd8,
        R9_MAX_SCAN_LINE  = 5'd9,
        R10_CURSOR_START  = 5'd10,
        R11_CURSOR_END    = 5'd11,
        R12_START_ADDR_HI = 5'd12,
        R13_START_ADDR_LO = 5'd13,
        R14_CURSOR_HI     = 5'd14,
        R15_CURSOR_LO     = 5'd15,
        R16_LPEN_HI       = 5'd16,
        R17_LPEN_LO       = 5'd17
    } crtc_reg_e;

    typedef enum logic {
        ACTIVE_ROWS = 1'b0,
        ADJUST      = 1'b1
    } crtc_state_e;

endpackage

// File: rtl/crtc_sync_pulse.sv
// Fixed-width sync pulse generator; width counts step_en_i strobes, a width of 0 means 16.
module crtc_sync_pulse (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en_i,
    input  logic       trigger_i,
    input  logic [3:0] width_i,
    output logic       pulse_o
);

    logic [3:0] remaining_q;
    logic       pulse_q;

    // A trigger arriving while steps remain is ignored; width-1 wraps 0 to 15 extra steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q <= 4'd0;
            pulse_q     <= 1'b0;
        end else if (step_en_i) begin
            if (remaining_q != 4'd0) begin
                remaining_q <= remaining_q - 4'd1;
                pulse_q     <= 1'b1;
            end else if (trigger_i) begin
                remaining_q <= width_i - 4'd1;
                pulse_q     <= 1'b1;
            end else begin
                pulse_q     <= 1'b0;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/crtc_video_timing.sv
// 6545-style raster timing: character/scan-line/row counters, syncs, display enable and refresh address.
module crtc_video_timing
    import crtc_pkg::*;
#(
    parameter int MA_WIDTH = crtc_pkg::MA_WIDTH,
    parameter int RA_WIDTH = crtc_pkg::RA_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                char_en,
    input  logic [7:0]          r0_h_total,
    input  logic [7:0]          r1_h_displayed,
    input  logic [7:0]          r2_h_sync_pos,
    input  logic [7:0]          r3_sync_widths,
    input  logic [6:0]          r4_v_total,
    input  logic [4:0]          r5_v_total_adj,
    input  logic [6:0]          r6_v_displayed,
    input  logic [6:0]          r7_v_sync_pos,
    input  logic [4:0]          r9_max_scan_line,
    input  logic [13:0]         r12_r13_start_addr,
    output logic                h_sync,
    output logic                v_sync,
    output logic                de,
    output logic [MA_WIDTH-1:0] ma,
    output logic [RA_WIDTH-1:0] ra,
    output logic                frame_start
);

    logic [7:0]          h_count_q, h_count_d;
    logic [RA_WIDTH-1:0] ra_count_q;
    logic [6:0]          row_count_q;
    crtc_state_e         state_q;
    logic [MA_WIDTH-1:0] row_base_q, row_base_d, base_cur;
    logic                de_q, frame_start_q;
    logic [MA_WIDTH-1:0] ma_q;
    logic [RA_WIDTH-1:0] ra_q;
    logic                line_end, row_end, adjust_done, frame_origin;
    logic                h_trigger, v_step, v_trigger;

    // The start address is sampled only on the first character of a frame, so writes wait a frame.
    always_comb begin
        line_end     = h_count_q >= r0_h_total;
        row_end      = line_end && (ra_count_q >= r9_max_scan_line) && (state_q == ACTIVE_ROWS);
        adjust_done  = line_end && (state_q == ADJUST)
                       && (({1'b0, ra_count_q} + 6'd1) >= {1'b0, r5_v_total_adj});
        frame_origin = (h_count_q == 8'd0) && (ra_count_q == '0) && (row_count_q == 7'd0)
                       && (state_q == ACTIVE_ROWS);
        base_cur     = frame_origin ? r12_r13_start_addr : row_base_q;
        h_count_d    = line_end ? 8'd0 : h_count_q + 8'd1;
        if (row_end) begin
            row_base_d = base_cur + {{(MA_WIDTH-8){1'b0}}, r1_h_displayed};
        end else begin
            row_base_d = base_cur;
        end
        h_trigger    = h_count_q == r2_h_sync_pos;
        v_step       = char_en && (h_count_q == 8'd0);
        v_trigger    = (row_count_q == r7_v_sync_pos) && (ra_count_q == '0) && (state_q == ACTIVE_ROWS);
    end

    // Outputs describe the character being stepped over, so they track the counters one step behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count_q     <= 8'd0;
            ra_count_q    <= '0;
            row_count_q   <= 7'd0;
            state_q       <= ACTIVE_ROWS;
            row_base_q    <= '0;
            de_q          <= 1'b0;
            ma_q          <= '0;
            ra_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= char_en && frame_origin;
            if (char_en) begin
                h_count_q  <= h_count_d;
                row_base_q <= row_base_d;
                ma_q       <= base_cur + {{(MA_WIDTH-8){1'b0}}, h_count_q};
                ra_q       <= ra_count_q;
                de_q       <= (h_count_q < r1_h_displayed) && (row_count_q < r6_v_displayed)
                              && (state_q == ACTIVE_ROWS);
                if (line_end) begin
                    case (state_q)
                        ACTIVE_ROWS: begin
                            if (ra_count_q >= r9_max_scan_line) begin
                                ra_count_q <= '0;
                                if (row_count_q >= r4_v_total) begin
                                    if (r5_v_total_adj == 5'd0) begin
                                        row_count_q <= 7'd0;
                                    end else begin
                                        row_count_q <= row_count_q + 7'd1;
                                        state_q     <= ADJUST;
                                    end
                                end else begin
                                    row_count_q <= row_count_q + 7'd1;
                                end
                            end else begin
                                ra_count_q <= ra_count_q + 1'b1;
                            end
                        end
                        ADJUST: begin
                            if (adjust_done) begin
                                ra_count_q  <= '0;
                                row_count_q <= 7'd0;
                                state_q     <= ACTIVE_ROWS;
                            end else begin
                                ra_count_q <= ra_count_q + 1'b1;
                            end
                        end
                        default: state_q <= ACTIVE_ROWS;
                    endcase
                end
            end
        end
    end

    crtc_sync_pulse u_h_sync (
        .clk       (clk),
        .reset     (reset),
        .step_en_i (char_en),
        .trigger_i (h_trigger),
        .width_i   (r3_sync_widths[3:0]),
        .pulse_o   (h_sync)
    );

    // v_sync steps once per scan line, on its first character.
    crtc_sync_pulse u_v_sync (
        .clk       (clk),
        .reset     (reset),
        .step_en_i (v_step),
        .trigger_i (v_trigger),
        .width_i   (r3_sync_widths[7:4]),
        .pulse_o   (v_sync)
    );

    assign de          = de_q;
    assign ma          = ma_q;
    assign ra          = ra_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_crtc_video_timing.sv
// Scoreboard bench for crtc_video_timing: directed register setups with hand-derived raster sequences.
module tb_crtc_video_timing;

    logic        clk = 1'b0;
    logic        reset, char_en;
    logic [7:0]  r0, r1, r2, r3;
    logic [6:0]  r4, r6, r7;
    logic [4:0]  r5, r9;
    logic [13:0] start;
    logic        h_sync, v_sync, de, frame_start;
    logic [13:0] ma;
    logic [4:0]  ra;

    always #5 clk = ~clk;

    crtc_video_timing dut (
        .clk                (clk),
        .reset              (reset),
        .char_en            (char_en),
        .r0_h_total         (r0),
        .r1_h_displayed     (r1),
        .r2_h_sync_pos      (r2),
        .r3_sync_widths     (r3),
        .r4_v_total         (r4),
        .r5_v_total_adj     (r5),
        .r6_v_displayed     (r6),
        .r7_v_sync_pos      (r7),
        .r9_max_scan_line   (r9),
        .r12_r13_start_addr (start),
        .h_sync             (h_sync),
        .v_sync             (v_sync),
        .de                 (de),
        .ma                 (ma),
        .ra                 (ra),
        .frame_start        (frame_start)
    );

    // Vector layout: {fs, hs, vs, de, ra[4:0], ma[13:0]}
    localparam logic [22:0] ALL  = 23'h7FFFFF;
    localparam logic [22:0] M_MA = 23'h003FFF;
    localparam logic [22:0] M_DE = 23'h080000;
    localparam logic [22:0] M_FS = 23'h400000;

    typedef struct {
        logic [22:0] val;
        logic [22:0] mask;
        string       tag;
        int          idx;
    } exp_t;

    exp_t expQ[$];
    exp_t cur, lastExp;
    logic haveLast = 1'b0;
    logic evQ = 1'b0;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [22:0] mkVec(logic fs, logic hs, logic vs, logic dv,
                                          logic [4:0] rv, logic [13:0] mv);
        return {fs, hs, vs, dv, rv, mv};
    endfunction

    // Config A frame: 4 chars x 2 scan lines x 2 rows = 16 steps, R1=2 per row.
    function automatic logic [22:0] expA(int k);
        int kk, l, h, row;
        kk  = k % 16;
        l   = kk / 4;
        h   = kk % 4;
        row = l / 2;
        return mkVec(kk == 0, h == 2, l >= 2, (h < 2) && (row == 0), 5'(l % 2), 14'(row * 2 + h));
    endfunction

    task automatic checkOutput(input string tag, input int idx, input logic [22:0] val,
                               input logic [22:0] mask);
        logic [22:0] act;
        act = {frame_start, h_sync, v_sync, de, ra, ma};
        checks++;
        if (((act ^ val) & mask) != 23'd0) begin
            errors++;
            $display("[TB] FAIL %s #%0d: got fs=%0b hs=%0b vs=%0b de=%0b ra=%0d ma=%h, expected fs=%0b hs=%0b vs=%0b de=%0b ra=%0d ma=%h (mask %h)",
                     tag, idx, act[22], act[21], act[20], act[19], act[18:14], act[13:0],
                     val[22], val[21], val[20], val[19], val[18:14], val[13:0], mask);
        end
    endtask

    task automatic applyStimulus(input logic en, input string tag, input int idx,
                                 input logic [22:0] val, input logic [22:0] mask);
        exp_t e;
        reset   = 1'b0;
        char_en = en;
        if (en) begin
            e.val  = val;
            e.mask = mask;
            e.tag  = tag;
            e.idx  = idx;
            expQ.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic applyReset(input string tag);
        exp_t e;
        reset   = 1'b1;
        char_en = 1'b1;
        e.val   = 23'd0;
        e.mask  = ALL;
        e.tag   = tag;
        e.idx   = 0;
        expQ.push_back(e);
        @(negedge clk);
        reset   = 1'b0;
        char_en = 1'b0;
    endtask

    task automatic configA();
        r0 = 8'd3; r1 = 8'd2; r2 = 8'd2; r3 = 8'h21;
        r4 = 7'd1; r5 = 5'd0; r6 = 7'd1; r7 = 7'd1; r9 = 5'd1;
        start = 14'h0000;
    endtask

    // Monitor: a cycle after any strobe or reset the DUT presents a new output; otherwise it must hold.
    always @(posedge clk) evQ <= reset || char_en;

    always @(negedge clk) begin
        if (evQ) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_output: got ma=%h with empty scoreboard, required none", ma);
            end else begin
                cur = expQ.pop_front();
                checkOutput(cur.tag, cur.idx, cur.val, cur.mask);
                lastExp  = cur;
                haveLast = 1'b1;
            end
        end else if (haveLast) begin
            checkOutput("hold", lastExp.idx, lastExp.val & ~M_FS, lastExp.mask | M_FS);
        end
    end

    initial begin
        int g, l, h, f, ln;
        logic [13:0] s;
        logic [22:0] m;
        reset   = 1'b0;
        char_en = 1'b0;
        configA();
        @(negedge clk);

        $display("[TB] basic raster, R5=0");
        applyReset("reset");
        for (int k = 0; k < 40; k++) applyStimulus(1'b1, "basic", k, expA(k), ALL);

        $display("[TB] adjust phase R5=3 and 16-line v_sync");
        r3 = 8'h01;
        r5 = 5'd3;
        applyReset("reset");
        for (int k = 0; k < 112; k++) begin
            g = k / 4;
            l = g % 7;
            h = k % 4;
            m = (l >= 4) ? (ALL & ~M_MA) : ALL;
            applyStimulus(1'b1, "adjust", k,
                mkVec((k % 28) == 0, h == 2, ((g >= 2) && (g <= 17)) || (g >= 23),
                      (h < 2) && (l < 2), 5'((l < 4) ? (l % 2) : (l - 4)),
                      14'((l < 2) ? h : (2 + h))), m);
        end

        $display("[TB] address wrap, deferred start address, h_sync across line end");
        r0 = 8'd3; r1 = 8'd4; r2 = 8'd3; r3 = 8'h12;
        r4 = 7'd1; r5 = 5'd0; r6 = 7'd1; r7 = 7'd0; r9 = 5'd0;
        start = 14'h3FFE;
        applyReset("reset");
        for (int k = 0; k < 24; k++) begin
            if (k == 10) start = 14'h0100;
            f  = k / 8;
            ln = (k % 8) / 4;
            h  = k % 4;
            s  = (f < 2) ? 14'h3FFE : 14'h0100;
            applyStimulus(1'b1, "wrap", k,
                mkVec((k % 8) == 0, (h == 3) || ((h == 0) && (k > 0)), (k % 8) < 4,
                      (k % 8) < 4, 5'd0, s + 14'(ln * 4 + h)), ALL);
        end

        $display("[TB] sparse strobes, then reset mid-frame");
        configA();
        applyReset("reset");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, "sparse", k, expA(k), ALL);
            for (int i = 0; i < 3; i++) applyStimulus(1'b0, "", 0, 23'd0, 23'd0);
        end
        applyReset("midreset");
        for (int k = 0; k < 6; k++) applyStimulus(1'b1, "restart", k, expA(k), ALL);

        $display("[TB] shrink R0 mid-line");
        r0 = 8'd40; r1 = 8'd50; r2 = 8'd100; r3 = 8'h11;
        r4 = 7'd0; r5 = 5'd0; r6 = 7'd1; r7 = 7'd0; r9 = 5'd0;
        start = 14'h0000;
        applyReset("reset");
        for (int k = 0; k <= 40; k++) begin
            if (k == 20) r0 = 8'd10;
            if (k <= 20) h = k;
            else h = (k - 21) % 11;
            applyStimulus(1'b1, "shrink", k,
                mkVec((k == 0) || ((k > 20) && (h == 0)), 1'b0, 1'b0, 1'b1, 5'd0, 14'(h)),
                M_MA | M_FS | M_DE);
        end

        applyStimulus(1'b0, "", 0, 23'd0, 23'd0);
        applyStimulus(1'b0, "", 0, 23'd0, 23'd0);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d outputs still expected, required 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
